led_serial_driver: RTL and testbench

//  Serialises a parallel status word (CPU flags, ALU op, register value) into the

---
 rtl/led_serial_driver.sv | 174 +++++++++++++++++
 tb/tb_led_serial_driver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_serial_driver.sv
// led_serial_driver: shifts a parallel status word MSB-first into a
// 74HC595-style LED chain (data / shift-clock / latch), with a
// load/busy/done handshake and a one-deep "last request wins" pending buffer.
module led_serial_driver #(
  parameter int WIDTH = 16,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_load,
  output logic             o_busy,
  output logic             o_pending,
  output logic             o_done,
  output logic             o_sclk,
  output logic             o_sdata,
  output logic             o_latch
);

  // DIV=1 still needs a 1-bit counter so the vector is never zero-width.
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic             busy_q, busy_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             latch_q, latch_d;
  logic             done_q, done_d;

  logic             div_end;
  logic [WIDTH-1:0] start_word;
  logic [WIDTH-1:0] shreg_shifted;

  // A fresh request outranks a buffered one when a frame starts.
  assign start_word    = i_load ? i_data : pend_data_q;
  assign div_end       = (div_cnt_q == DIV_LAST);
  assign shreg_shifted = shreg_q << 1;

  // Next-state and next-output logic; every output is precomputed here so it
  // leaves the block straight from a flop.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    busy_d      = busy_q;
    sclk_d      = sclk_q;
    sdata_d     = sdata_q;
    latch_d     = latch_q;
    done_d      = 1'b0;

    // While a frame runs, requests park in the pending buffer, newest wins.
    if (state_q != ST_IDLE && i_load) begin
      pend_d      = 1'b1;
      pend_data_d = i_data;
    end

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (i_load || pend_q) begin
          state_d   = ST_SHIFT_LO;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          shreg_d   = start_word;
          pend_d    = 1'b0;
          busy_d    = 1'b1;
          sclk_d    = 1'b0;
          sdata_d   = start_word[WIDTH-1];
          latch_d   = 1'b0;
        end
      end

      ST_SHIFT_LO: begin
        if (div_end) begin
          div_cnt_d = '0;
          state_d   = ST_SHIFT_HI;
          sclk_d    = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_SHIFT_HI: begin
        if (div_end) begin
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          sclk_d    = 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_LATCH;
            sdata_d = 1'b0;
            latch_d = 1'b1;
          end else begin
            state_d = ST_SHIFT_LO;
            shreg_d = shreg_shifted;
            sdata_d = shreg_shifted[WIDTH-1];
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      ST_LATCH: begin
        if (div_end) begin
          div_cnt_d = '0;
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          latch_d   = 1'b0;
          done_d    = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      busy_q      <= 1'b0;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      latch_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      busy_q      <= busy_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      latch_q     <= latch_d;
      done_q      <= done_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_pending = pend_q;
  assign o_done    = done_q;
  assign o_sclk    = sclk_q;
  assign o_sdata   = sdata_q;
  assign o_latch   = latch_q;

endmodule

// File: tb/tb_led_serial_driver.sv
// Bench for led_serial_driver: two instances (DIV=2 and DIV=1, WIDTH=16)
// checked every cycle against a timeline model of the frame, plus a
// software shift-register chain that records every latched word.
module tb_led_serial_driver;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ld = 2'b00;
  logic [W-1:0] dat [2];

  logic [1:0] busy_w, pend_w, done_w, sclk_w, sdata_w, latch_w;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  led_serial_driver #(.WIDTH(W), .DIV(2)) u_dut0 (
    .clk(clk), .reset(rst_n), .i_data(dat[0]), .i_load(ld[0]),
    .o_busy(busy_w[0]), .o_pending(pend_w[0]), .o_done(done_w[0]),
    .o_sclk(sclk_w[0]), .o_sdata(sdata_w[0]), .o_latch(latch_w[0])
  );

  led_serial_driver #(.WIDTH(W), .DIV(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .i_data(dat[1]), .i_load(ld[1]),
    .o_busy(busy_w[1]), .o_pending(pend_w[1]), .o_done(done_w[1]),
    .o_sclk(sclk_w[1]), .o_sdata(sdata_w[1]), .o_latch(latch_w[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int divof(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: frame as a timeline ----------------
  bit          m_act [2];
  int          m_t   [2];
  logic [W-1:0] m_word [2];
  bit          m_pv  [2];
  logic [W-1:0] m_pw  [2];
  logic e_busy [2], e_sclk [2], e_sdata [2], e_latch [2], e_done [2], e_pend [2];
  logic [W-1:0] mq0 [$], mq1 [$];   // words the model expects to be latched
  logic [W-1:0] lq0 [$], lq1 [$];   // words the chain actually latched

  task automatic model_step(input int k);
    int d, shift_len, total;
    bit idle;
    d         = divof(k);
    shift_len = 2 * d * W;
    total     = shift_len + d;
    idle      = !m_act[k] || (m_t[k] == total);
    if (!rst_n) begin
      m_act[k] = 0; m_t[k] = 0; m_pv[k] = 0;
    end else if (idle) begin
      if (ld[k]) begin
        m_word[k] = dat[k]; m_pv[k] = 0; m_act[k] = 1; m_t[k] = 0;
      end else if (m_pv[k]) begin
        m_word[k] = m_pw[k]; m_pv[k] = 0; m_act[k] = 1; m_t[k] = 0;
      end else begin
        m_act[k] = 0;
      end
    end else begin
      if (ld[k]) begin m_pv[k] = 1; m_pw[k] = dat[k]; end
      m_t[k]++;
      if (m_t[k] == shift_len) begin
        if (k == 0) mq0.push_back(m_word[k]); else mq1.push_back(m_word[k]);
      end
    end
    e_busy[k] = 0; e_sclk[k] = 0; e_sdata[k] = 0; e_latch[k] = 0; e_done[k] = 0;
    e_pend[k] = m_pv[k];
    if (m_act[k]) begin
      if (m_t[k] < shift_len) begin
        e_busy[k]  = 1;
        e_sclk[k]  = ((m_t[k] % (2 * d)) >= d);
        e_sdata[k] = m_word[k][W - 1 - m_t[k] / (2 * d)];
      end else if (m_t[k] < total) begin
        e_busy[k]  = 1;
        e_latch[k] = 1;
      end else begin
        e_done[k]  = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- compare process + software LED chain ----------------
  logic [W-1:0] ch_sr [2];
  logic prv_sclk [2], prv_latch [2];
  int   rises [2], latch_cyc [2];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy%0d", k),  32'(busy_w[k]),  32'(e_busy[k]));
        check($sformatf("pend%0d", k),  32'(pend_w[k]),  32'(e_pend[k]));
        check($sformatf("done%0d", k),  32'(done_w[k]),  32'(e_done[k]));
        check($sformatf("sclk%0d", k),  32'(sclk_w[k]),  32'(e_sclk[k]));
        check($sformatf("sdata%0d", k), 32'(sdata_w[k]), 32'(e_sdata[k]));
        check($sformatf("latch%0d", k), 32'(latch_w[k]), 32'(e_latch[k]));
        if (sclk_w[k] === 1'b1 && prv_sclk[k] !== 1'b1) begin
          ch_sr[k] = {ch_sr[k][W-2:0], sdata_w[k]};
          rises[k]++;
        end
        if (latch_w[k] === 1'b1) latch_cyc[k]++;
        if (latch_w[k] === 1'b1 && prv_latch[k] !== 1'b1) begin
          if (k == 0) lq0.push_back(ch_sr[k]); else lq1.push_back(ch_sr[k]);
        end
        prv_sclk[k]  = sclk_w[k];
        prv_latch[k] = latch_w[k];
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic pulse(input int k, input logic [W-1:0] v);
    dat[k] = v;
    ld[k]  = 1'b1;
    @(negedge clk);
    ld[k]  = 1'b0;
  endtask

  task automatic wait_done(input int k, output int at);
    bit found;
    found = 0;
    at = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (done_w[k] === 1'b1) begin found = 1; at = cyc; end
    end
    check($sformatf("done_seen%0d", k), 32'(found), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc, at, r0, lc0, n0, nz;
    dat[0] = '0; dat[1] = '0;
    for (int k = 0; k < 2; k++) begin
      ch_sr[k] = '0; prv_sclk[k] = 0; prv_latch[k] = 0; rises[k] = 0; latch_cyc[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy0", 32'(busy_w[0]), 32'd0);
    check("rst_pend1", 32'(pend_w[1]), 32'd0);
    rst_n = 1'b1;

    // Idle for 100 cycles: nothing toggles.
    nz = 0;
    repeat (100) begin
      @(negedge clk);
      if ((busy_w | sclk_w | latch_w | done_w) != 2'b00) nz++;
    end
    check("t6_idle_quiet", 32'(nz), 32'd0);

    // Single frame A5C3 on DIV=2.
    r0 = rises[0]; lc0 = latch_cyc[0]; n0 = lq0.size();
    pulse(0, 16'hA5C3);
    acc = cyc;
    wait_done(0, at);
    check("t1_latency", 32'(at - acc), 32'd66);
    check("t1_sclk_rises", 32'(rises[0] - r0), 32'd16);
    check("t1_latch_cycles", 32'(latch_cyc[0] - lc0), 32'd2);
    check("t1_latch_count", 32'(lq0.size() - n0), 32'd1);
    check("t1_word", 32'(lq0[lq0.size()-1]), 32'h0000A5C3);
    $display("[TB] frame k=0 word=a5c3 latency=%0d", at - acc);
    @(negedge clk);
    check("t1_busy_after", 32'(busy_w[0]), 32'd0);
    check("t1_done_width", 32'(done_w[0]), 32'd0);

    // Pending request queued mid-frame, sent with no gap.
    pulse(0, 16'h0001);
    repeat (20) @(negedge clk);
    pulse(0, 16'h8000);
    check("t2_pending", 32'(pend_w[0]), 32'd1);
    wait_done(0, at);
    @(negedge clk);
    check("t2_no_gap_busy", 32'(busy_w[0]), 32'd1);
    check("t2_pend_cleared", 32'(pend_w[0]), 32'd0);
    wait_done(0, at);
    check("t2_word1", 32'(lq0[lq0.size()-2]), 32'h00000001);
    check("t2_word2", 32'(lq0[lq0.size()-1]), 32'h00008000);
    $display("[TB] frames k=0 words=0001,8000");

    // Last request wins.
    n0 = lq0.size();
    pulse(0, 16'h3333);
    repeat (5) @(negedge clk);
    pulse(0, 16'h1111);
    repeat (7) @(negedge clk);
    pulse(0, 16'h2222);
    wait_done(0, at);
    wait_done(0, at);
    check("t3_count", 32'(lq0.size() - n0), 32'd2);
    check("t3_word1", 32'(lq0[lq0.size()-2]), 32'h00003333);
    check("t3_word2", 32'(lq0[lq0.size()-1]), 32'h00002222);
    $display("[TB] frames k=0 words=3333,2222 (1111 overwritten)");

    // Reset mid-frame (bit 7), with a simultaneous load on the other instance.
    n0 = lq0.size();
    pulse(0, 16'hBEEF);
    repeat (28) @(negedge clk);
    rst_n = 1'b0;
    dat[1] = 16'h1234;
    ld[1] = 1'b1;
    @(negedge clk);
    ld[1] = 1'b0;
    check("t4_busy", 32'(busy_w[0]), 32'd0);
    check("t4_sclk", 32'(sclk_w[0]), 32'd0);
    check("t4_sdata", 32'(sdata_w[0]), 32'd0);
    check("t4_pend", 32'(pend_w[0]), 32'd0);
    check("t4_rst_wins_busy1", 32'(busy_w[1]), 32'd0);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("t4_no_latch", 32'(lq0.size() - n0), 32'd0);
    pulse(0, 16'h5A5A);
    wait_done(0, at);
    check("t4_word_after", 32'(lq0[lq0.size()-1]), 32'h00005A5A);
    $display("[TB] frame k=0 word=5a5a after reset abort");

    // DIV=1: reload in the done cycle.
    r0 = rises[1];
    pulse(1, 16'hFFFF);
    acc = cyc;
    wait_done(1, at);
    check("t5_latency", 32'(at - acc), 32'd33);
    pulse(1, 16'h0000);
    check("t5_accept_busy", 32'(busy_w[1]), 32'd1);
    check("t5_done_width", 32'(done_w[1]), 32'd0);
    wait_done(1, at);
    check("t5_sclk_rises", 32'(rises[1] - r0), 32'd32);
    check("t5_word1", 32'(lq1[lq1.size()-2]), 32'h0000FFFF);
    check("t5_word2", 32'(lq1[lq1.size()-1]), 32'h00000000);
    $display("[TB] frames k=1 words=ffff,0000");

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 2; k++) begin
        ld[k]  = ($urandom_range(99) < 4);
        dat[k] = 16'($urandom);
      end
      rst_n = ($urandom_range(1999) != 0);
      @(negedge clk);
    end
    ld = 2'b00;
    rst_n = 1'b1;
    repeat (200) @(negedge clk);

    check("latched_count0", 32'(lq0.size()), 32'(mq0.size()));
    check("latched_count1", 32'(lq1.size()), 32'(mq1.size()));
    for (int i = 0; i < lq0.size() && i < mq0.size(); i++)
      check("latched_word0", 32'(lq0[i]), 32'(mq0[i]));
    for (int i = 0; i < lq1.size() && i < mq1.size(); i++)
      check("latched_word1", 32'(lq1[i]), 32'(mq1[i]));
    $display("[TB] random phase: %0d + %0d frames latched", lq0.size(), lq1.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
